ita_scroll_scan_ctrl: RTL and testbench

//  Drives a 12-digit 14-segment multiplexed display from a host-writable message buffer.

---
 rtl/ita_disp_pkg.sv | 35 +++
 rtl/ita_scan_timer.sv | 88 ++++++++
 rtl/ita_scroll_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ita_scroll_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_disp_pkg.sv
// ----------------------------------------------------------------------------
// ita_disp_pkg
// Shared constants for the 12-digit 14-segment display path: geometry of the
// scan (digits, slots per dwell), segment word width and a small glyph set
// for benches and host-side character ROMs.
//
// Segment bit order (MSB first): a b c d e f g1 g2 h i j k l m
//   bit13 = a ... bit0 = last diagonal.
// ----------------------------------------------------------------------------
package ita_disp_pkg;

    localparam int NUM_DIGITS = 12;
    localparam int SEG_W      = 14;
    localparam int SLOTS      = 16;
    localparam int SLOT_W     = 4;
    localparam int DIGIT_W    = 4;

    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SLOTS - 1);

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t GLYPH_SPACE = 14'b00000000000000;
    localparam seg_t GLYPH_H     = 14'b01101111000000;
    localparam seg_t GLYPH_E     = 14'b10011111000000;
    localparam seg_t GLYPH_L     = 14'b00011100000000;
    localparam seg_t GLYPH_O     = 14'b11111100000000;
    localparam seg_t GLYPH_DASH  = 14'b00000011000000;

    // One-hot digit select, bit0 = leftmost digit.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [DIGIT_W-1:0] d);
        return NUM_DIGITS'(1) << d;
    endfunction

endpackage

// File: rtl/ita_scan_timer.sv
// ----------------------------------------------------------------------------
// ita_scan_timer
// Nested scan counters for the multiplexed display:
//   cyc   0..SLOT_CYCLES-1, slot 0..15 (advances on cyc wrap),
//   digit 0..11 (advances on slot wrap); digit 11 -> 0 closes a frame.
// While en_i is low the counters sit at the frame origin so that the next
// enabled cycle is the entry of digit 0.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   en_i           count enable; low forces counters to frame start
//   digit_entry_o  current state is slot 0 / cyc 0 of a digit (enabled)
//   frame_begin_o  digit entry of digit 0
//   frame_end_o    current state is the last cycle of the frame (enabled)
//   slot_o         current slot
//   digit_o        current digit
// ----------------------------------------------------------------------------
module ita_scan_timer
    import ita_disp_pkg::*;
#(
    parameter int SLOT_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic               digit_entry_o,
    output logic               frame_begin_o,
    output logic               frame_end_o,
    output logic [SLOT_W-1:0]  slot_o,
    output logic [DIGIT_W-1:0] digit_o
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYC = CW'(SLOT_CYCLES - 1);

    logic [CW-1:0]      cyc_q,   cyc_d;
    logic [SLOT_W-1:0]  slot_q,  slot_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;

    logic cyc_last;
    logic slot_last;
    logic digit_last;

    assign cyc_last   = (cyc_q == LAST_CYC);
    assign slot_last  = (slot_q == LAST_SLOT);
    assign digit_last = (digit_q == LAST_DIGIT);

    always_comb begin
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        digit_d = digit_q;
        if (!en_i) begin
            cyc_d   = '0;
            slot_d  = '0;
            digit_d = '0;
        end else if (cyc_last) begin
            cyc_d = '0;
            if (slot_last) begin
                slot_d  = '0;
                digit_d = digit_last ? '0 : digit_q + DIGIT_W'(1);
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end else begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q   <= '0;
            slot_q  <= '0;
            digit_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            slot_q  <= slot_d;
            digit_q <= digit_d;
        end
    end

    assign digit_entry_o = en_i && (slot_q == '0) && (cyc_q == '0);
    assign frame_begin_o = digit_entry_o && (digit_q == '0);
    assign frame_end_o   = en_i && digit_last && slot_last && cyc_last;
    assign slot_o        = slot_q;
    assign digit_o       = digit_q;

endmodule

// File: rtl/ita_scroll_scan_ctrl.sv
// ----------------------------------------------------------------------------
// ita_scroll_scan_ctrl
// Multiplexed scan controller for a 12-digit 14-segment display. Holds a
// host-writable message buffer, shows a 12-character window of it starting
// at the scroll offset, and time-slices each digit into 16 slots: slot 0 is
// a dark guard against ghosting, slots 1..bright are lit, the rest dark.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high (priority over all inputs)
//   en_i           1 = scanning, 0 = dark with timing held at frame start
//   bright_i       lit slots per dwell, sampled at each digit entry
//   scroll_en_i    advance the window every SCROLL_FRAMES frames
//   wr_en_i        buffer write strobe (never stalled)
//   wr_addr_i      buffer index; indices >= MSG_LEN are dropped
//   wr_data_i      raw segment pattern
//   sel_o          one-hot digit select, bit0 = leftmost
//   segm_o         segment drive
//   frame_start_o  pulse on the first output cycle of digit 0
//   offset_o       buffer index currently shown on digit 0
// ----------------------------------------------------------------------------
module ita_scroll_scan_ctrl
    import ita_disp_pkg::*;
#(
    parameter  int SLOT_CYCLES   = 2,
    parameter  int MSG_LEN       = 32,
    parameter  int SCROLL_FRAMES = 64,
    localparam int AW            = $clog2(MSG_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [3:0]            bright_i,
    input  logic                  scroll_en_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [SEG_W-1:0]      wr_data_i,
    output logic [NUM_DIGITS-1:0] sel_o,
    output logic [SEG_W-1:0]      segm_o,
    output logic                  frame_start_o,
    output logic [AW-1:0]         offset_o
);

    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [FW-1:0] LAST_FRAME  = FW'(SCROLL_FRAMES - 1);
    localparam logic [AW:0]   MSG_LEN_X   = (AW+1)'(MSG_LEN);
    localparam logic [AW-1:0] LAST_OFFSET = AW'(MSG_LEN - 1);

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic               digit_entry;
    logic               frame_begin;
    logic               frame_end;
    logic [SLOT_W-1:0]  slot;
    logic [DIGIT_W-1:0] digit;

    ita_scan_timer #(
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .digit_entry_o (digit_entry),
        .frame_begin_o (frame_begin),
        .frame_end_o   (frame_end),
        .slot_o        (slot),
        .digit_o       (digit)
    );

    // ------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------
    seg_t msg_q [MSG_LEN];

    // Decoding per entry drops out-of-range addresses when MSG_LEN is not
    // a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= GLYPH_SPACE;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if (wr_addr_i == AW'(i)) begin
                    msg_q[i] <= wr_data_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Window index: offset + digit, folded once into 0..MSG_LEN-1.
    // MSG_LEN >= 12 keeps the sum below 2*MSG_LEN, so one subtract suffices.
    // ------------------------------------------------------------------
    logic [AW-1:0] offset_q, offset_d;
    logic [AW:0]   idx_sum;
    logic [AW-1:0] rd_idx;
    seg_t          rd_pat;

    assign idx_sum = {1'b0, offset_q} + (AW+1)'(digit);

    always_comb begin
        if (idx_sum >= MSG_LEN_X) begin
            rd_idx = AW'(idx_sum - MSG_LEN_X);
        end else begin
            rd_idx = AW'(idx_sum);
        end
    end

    // Reads the registered buffer, so a write landing on the entry edge is
    // not visible until the next visit to that digit.
    always_comb begin
        rd_pat = GLYPH_SPACE;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (rd_idx == AW'(i)) begin
                rd_pat = msg_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scroll
    // ------------------------------------------------------------------
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        if (!scroll_en_i) begin
            frame_cnt_d = '0;
        end else if (frame_end) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = '0;
                offset_d    = (offset_q == LAST_OFFSET) ? '0 : offset_q + AW'(1);
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit latches and registered outputs
    // ------------------------------------------------------------------
    seg_t                  pat_q;
    logic [3:0]            bright_q;
    logic [NUM_DIGITS-1:0] sel_q,  sel_d;
    seg_t                  segm_q, segm_d;
    logic                  fs_q;
    logic                  lit;

    // Slot 0 is always dark; bright_q is only read from slot 1 onward, after
    // the entry cycle has refreshed it.
    assign lit = en_i && (slot != '0) && (slot <= bright_q);

    always_comb begin
        sel_d  = '0;
        segm_d = GLYPH_SPACE;
        if (lit) begin
            sel_d  = digit_onehot(digit);
            segm_d = pat_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_q       <= GLYPH_SPACE;
            bright_q    <= '0;
            sel_q       <= '0;
            segm_q      <= GLYPH_SPACE;
            fs_q        <= 1'b0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (digit_entry) begin
                pat_q    <= rd_pat;
                bright_q <= bright_i;
            end
            sel_q       <= sel_d;
            segm_q      <= segm_d;
            fs_q        <= frame_begin;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign sel_o         = sel_q;
    assign segm_o        = segm_q;
    assign frame_start_o = fs_q;
    assign offset_o      = offset_q;

endmodule

// File: tb/tb_ita_scroll_scan_ctrl.sv
module tb_ita_scroll_scan_ctrl;

    localparam int SC    = 2;
    localparam int ML    = 16;
    localparam int SF    = 2;
    localparam int AW    = 4;
    localparam int FRAME = 384;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  bright;
    logic        scroll_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [13:0] wr_data;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        frame_start;
    logic [3:0]  offset;

    ita_scroll_scan_ctrl #(
        .SLOT_CYCLES   (SC),
        .MSG_LEN       (ML),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .bright_i      (bright),
        .scroll_en_i   (scroll_en),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .sel_o         (sel),
        .segm_o        (segm),
        .frame_start_o (frame_start),
        .offset_o      (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [11:0] sel_a  [FRAME];
    logic [13:0] segm_a [FRAME];
    logic        fs_a   [FRAME];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [13:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Always advances at least one cycle, then stops on the next frame_start.
    task automatic wait_fs(input string tag);
        int n;
        tick();
        n = 1;
        while (!frame_start && n < FRAME + 4) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, frame_start}, 32'd1);
    endtask

    task automatic capture_frame(input string tag);
        wait_fs(tag);
        for (int p = 0; p < FRAME; p++) begin
            sel_a[p]  = sel;
            segm_a[p] = segm;
            fs_a[p]   = frame_start;
            tick();
        end
    endtask

    task automatic wait_offset(input logic [3:0] target, input int max_frames, input string tag);
        int n;
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < max_frames) begin
            wait_fs({tag, "_fs"});
            if (offset == target) found = 1'b1;
            n++;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz;
        int fsn;
        int lit;
        int bad;
        logic [3:0] exp_off [5];

        rst = 1'b1; en = 1'b0; bright = 4'd0; scroll_en = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // ---- reset state
        ticks(3);
        chk("rst_sel",    {20'd0, sel},  32'd0);
        chk("rst_segm",   {18'd0, segm}, 32'd0);
        chk("rst_fs",     {31'd0, frame_start}, 32'd0);
        chk("rst_offset", {28'd0, offset}, 32'd0);

        // ---- 1: empty buffer, bright 0 -> dark, frame_start every 384
        rst = 1'b0; en = 1'b1;
        capture_frame("t1_fs");
        nz = 0; fsn = 0;
        for (int p = 0; p < FRAME; p++) begin
            if (sel_a[p] != 0 || segm_a[p] != 0) nz++;
            if (fs_a[p]) fsn++;
        end
        chk("t1_dark",      nz, 0);
        chk("t1_fs_count",  fsn, 1);
        chk("t1_fs_first",  {31'd0, fs_a[0]}, 32'd1);
        chk("t1_fs_period", {31'd0, frame_start}, 32'd1);

        // ---- 2: buf[0]=1BC0, bright 15
        bright = 4'd15;
        wr(4'd0, 14'h1BC0);
        capture_frame("t2_fs");
        lit = 0;
        for (int p = 0; p < 32; p++) if (sel_a[p] == 12'h001 && segm_a[p] == 14'h1BC0) lit++;
        chk("t2_lit_cycles", lit, 30);
        chk("t2_guard0",   {20'd0, sel_a[0]},   32'h000);
        chk("t2_guard1",   {20'd0, sel_a[1]},   32'h000);
        chk("t2_sel2",     {20'd0, sel_a[2]},   32'h001);
        chk("t2_segm2",    {18'd0, segm_a[2]},  32'h1BC0);
        chk("t2_sel31",    {20'd0, sel_a[31]},  32'h001);
        chk("t2_guard32",  {20'd0, sel_a[32]},  32'h000);
        chk("t2_sel34",    {20'd0, sel_a[34]},  32'h002);
        chk("t2_segm34",   {18'd0, segm_a[34]}, 32'h0);
        chk("t2_sel383",   {20'd0, sel_a[383]}, 32'h800);

        // ---- 3: bright 4, then a mid-dwell change
        bright = 4'd4;
        capture_frame("t3_fs");
        lit = 0;
        for (int p = 0; p < 32; p++) if (sel_a[p] == 12'h001) lit++;
        chk("t3_lit_cycles", lit, 8);
        chk("t3_sel9",   {20'd0, sel_a[9]},   32'h001);
        chk("t3_segm9",  {18'd0, segm_a[9]},  32'h1BC0);
        chk("t3_sel10",  {20'd0, sel_a[10]},  32'h000);
        chk("t3_sel34",  {20'd0, sel_a[34]},  32'h002);
        chk("t3_sel42",  {20'd0, sel_a[42]},  32'h000);
        ticks(5);                    // pos 5 of digit 0
        bright = 4'd15;
        ticks(4);
        chk("t3_mid_sel9",  {20'd0, sel}, 32'h001);
        tick();
        chk("t3_mid_sel10", {20'd0, sel}, 32'h000);
        ticks(24);                   // pos 34: digit 1 slot 1
        chk("t3_next_sel34", {20'd0, sel}, 32'h002);
        ticks(29);                   // pos 63: digit 1 slot 15
        chk("t3_next_sel63", {20'd0, sel}, 32'h002);

        // ---- 5: writes to buf[0] mid-dwell and on the entry edge
        wait_fs("t5_fs0");
        ticks(10);
        wr(4'd0, 14'h2AAA);          // lands at pos 11
        ticks(9);                    // pos 20
        chk("t5_mid_old", {18'd0, segm}, 32'h1BC0);
        ticks(363);                  // pos 383
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 14'h0155;
        tick();                      // entry edge of next frame
        wr_en = 1'b0;
        chk("t5_entry_fs", {31'd0, frame_start}, 32'd1);
        ticks(2);
        chk("t5_next_visit", {18'd0, segm}, 32'h2AAA);
        wait_fs("t5_fs1");
        ticks(2);
        chk("t5_entry_write", {18'd0, segm}, 32'h0155);

        // ---- 4: scroll
        for (int i = 0; i < 16; i++) wr(4'(i), 14'(i + 1));
        wait_fs("t4_fs0");
        scroll_en = 1'b1;
        exp_off[0] = 4'd0; exp_off[1] = 4'd0; exp_off[2] = 4'd1;
        exp_off[3] = 4'd1; exp_off[4] = 4'd2;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) wait_fs("t4_fs");
            ticks(2);
            chk($sformatf("t4_offset_f%0d", k), {28'd0, offset}, {28'd0, exp_off[k]});
            chk($sformatf("t4_segm_f%0d", k),   {18'd0, segm},   {28'd0, exp_off[k]} + 32'd1);
        end
        wait_offset(4'd5, 10, "t4_reach5");
        ticks(2);
        chk("t4_off5_d0",   {18'd0, segm}, 32'h6);
        ticks(352);                  // pos 354: digit 11 slot 1
        chk("t4_off5_sel11",  {20'd0, sel},  32'h800);
        chk("t4_off5_segm11", {18'd0, segm}, 32'h1);
        wait_offset(4'd15, 25, "t4_reach15");
        ticks(2);
        chk("t4_off15_d0", {18'd0, segm}, 32'h10);
        ticks(32);                   // pos 34: digit 1
        chk("t4_off15_d1", {18'd0, segm}, 32'h1);
        wait_offset(4'd0, 3, "t4_wrap0");
        ticks(2);
        chk("t4_wrap_d0", {18'd0, segm}, 32'h1);

        // ---- 6: reset mid-frame, then en low for 50 cycles
        wait_fs("t6_fs0");
        ticks(197);                  // digit 6, slot 2
        chk("t6_pre_sel", {20'd0, sel}, 32'h040);
        rst = 1'b1;
        tick();
        chk("t6_rst_sel",    {20'd0, sel},  32'd0);
        chk("t6_rst_segm",   {18'd0, segm}, 32'd0);
        chk("t6_rst_fs",     {31'd0, frame_start}, 32'd0);
        chk("t6_rst_offset", {28'd0, offset}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_restart_fs", {31'd0, frame_start}, 32'd1);
        ticks(2);
        chk("t6_restart_sel",  {20'd0, sel},  32'h001);
        chk("t6_restart_segm", {18'd0, segm}, 32'h0);
        wait_offset(4'd1, 4, "t6_reach1");
        ticks(100);                  // digit 3, slot 2
        chk("t6_pre_en_sel", {20'd0, sel}, 32'h008);
        en = 1'b0;
        tick();
        chk("t6_en0_sel",  {20'd0, sel},  32'd0);
        chk("t6_en0_segm", {18'd0, segm}, 32'd0);
        chk("t6_en0_fs",   {31'd0, frame_start}, 32'd0);
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (sel != 0 || segm != 0 || frame_start || offset != 4'd1) bad++;
        end
        chk("t6_en0_hold", bad, 0);
        chk("t6_en0_offset", {28'd0, offset}, 32'd1);
        en = 1'b1;
        tick();
        chk("t6_en1_fs", {31'd0, frame_start}, 32'd1);
        ticks(2);
        chk("t6_en1_sel", {20'd0, sel}, 32'h001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
